// File: rtl/ser_tx_piso_if.sv
// ser_tx_piso_if: valid/ready word handshake feeding the serial transmitter.
//   in_data  - word to transmit (master -> slave)
//   in_valid - in_data is valid (master -> slave)
//   in_ready - transmitter FIFO can accept a word (slave -> master)
interface ser_tx_piso_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ser_tx_piso.sv
// ser_tx_piso: buffered parallel-in serial-out transmitter with divided clock and frame chip select.
//   clk          - system clock, all logic on posedge
//   rst_n        - asynchronous active-low reset
//   i_bus        - word handshake (in_data/in_valid/in_ready) into the input FIFO
//   o_ser_clk    - serial clock, idles low, slave samples on rising edge
//   o_ser_out    - serial data, changes on ser_clk falling edge or at frame load
//   o_ser_cs_n   - active-low chip select, low for one frame
//   o_frame_done - one-cycle pulse at frame completion
//   o_busy       - FIFO non-empty or frame/gap in progress
//   o_fifo_level - words currently buffered
module ser_tx_piso #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 1,
    parameter int MSB_FIRST  = 1,
    parameter int GAP        = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    ser_tx_piso_if.slave                     i_bus,
    output logic                             o_ser_clk,
    output logic                             o_ser_out,
    output logic                             o_ser_cs_n,
    output logic                             o_frame_done,
    output logic                             o_busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  o_fifo_level
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (GAP > 2) ? $clog2(GAP - 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]     r_wr, r_rd;
    logic [LW-1:0]     r_level;
    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_sh;
    logic [BW-1:0]     r_bit;
    logic [DW-1:0]     r_div;
    logic [GW-1:0]     r_gap;
    logic              r_sclk, r_out, r_cs_n, r_done;

    logic              w_push, w_pop, w_div_tc, w_first, w_nbit;
    logic [DATA_W-1:0] w_head, w_next;

    assign i_bus.in_ready = r_level < LW'(FIFO_DEPTH);
    assign w_push   = i_bus.in_valid && i_bus.in_ready;
    assign w_pop    = (r_state == S_IDLE) && (r_level != '0);
    assign w_head   = r_mem[r_rd];
    assign w_first  = (MSB_FIRST != 0) ? w_head[DATA_W-1] : w_head[0];
    assign w_next   = (MSB_FIRST != 0) ? {r_sh[DATA_W-2:0], 1'b0} : {1'b0, r_sh[DATA_W-1:1]};
    assign w_nbit   = (MSB_FIRST != 0) ? w_next[DATA_W-1] : w_next[0];
    assign w_div_tc = r_div == DW'(CLK_DIV - 1);

    assign o_ser_clk    = r_sclk;
    assign o_ser_out    = r_out;
    assign o_ser_cs_n   = r_cs_n;
    assign o_frame_done = r_done;
    assign o_fifo_level = r_level;
    assign o_busy       = (r_state != S_IDLE) || (r_level != '0);

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_bus.in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + PW'(1);
            if (w_pop) r_rd <= r_rd + PW'(1);
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
        end
    end

    // The GAP state covers GAP-1 high cycles; the IDLE cycle that pops the
    // next word supplies the last one, so cs_n stays high max(GAP,1) cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_sh    <= '0;
            r_bit   <= '0;
            r_div   <= '0;
            r_gap   <= '0;
            r_sclk  <= 1'b0;
            r_out   <= 1'b0;
            r_cs_n  <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_level != '0) begin
                        r_sh    <= w_head;
                        r_out   <= w_first;
                        r_cs_n  <= 1'b0;
                        r_bit   <= BW'(DATA_W);
                        r_div   <= '0;
                        r_sclk  <= 1'b0;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_div <= w_div_tc ? '0 : r_div + DW'(1);
                    if (w_div_tc) begin
                        r_sclk <= ~r_sclk;
                        if (!r_sclk) begin
                            r_bit <= r_bit - BW'(1);
                        end else if (r_bit != '0) begin
                            r_sh  <= w_next;
                            r_out <= w_nbit;
                        end else begin
                            r_cs_n  <= 1'b1;
                            r_out   <= 1'b0;
                            r_done  <= 1'b1;
                            r_gap   <= '0;
                            r_state <= (GAP > 1) ? S_GAP : S_IDLE;
                        end
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + GW'(1);
                    if (r_gap == GW'(GAP - 2)) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ser_tx_piso.sv
// tb_ser_tx_piso: three transmitter configurations driven with directed and random words,
// the serial stream decoded back into words and compared with the accepted-word queue.
module tb_ser_tx_piso;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ser_tx_piso_if #(.DATA_W(32)) b0 ();
    ser_tx_piso_if #(.DATA_W(32)) b1 ();
    ser_tx_piso_if #(.DATA_W(16)) b2 ();

    logic       sc [3];
    logic       so [3];
    logic       cs [3];
    logic       dn [3];
    logic       bz [3];
    logic [2:0] lv [3];

    ser_tx_piso u0 (
        .clk(clk), .rst_n(rst_n), .i_bus(b0),
        .o_ser_clk(sc[0]), .o_ser_out(so[0]), .o_ser_cs_n(cs[0]),
        .o_frame_done(dn[0]), .o_busy(bz[0]), .o_fifo_level(lv[0])
    );
    ser_tx_piso #(.MSB_FIRST(0), .GAP(0)) u1 (
        .clk(clk), .rst_n(rst_n), .i_bus(b1),
        .o_ser_clk(sc[1]), .o_ser_out(so[1]), .o_ser_cs_n(cs[1]),
        .o_frame_done(dn[1]), .o_busy(bz[1]), .o_fifo_level(lv[1])
    );
    ser_tx_piso #(.DATA_W(16), .CLK_DIV(3)) u2 (
        .clk(clk), .rst_n(rst_n), .i_bus(b2),
        .o_ser_clk(sc[2]), .o_ser_out(so[2]), .o_ser_cs_n(cs[2]),
        .o_frame_done(dn[2]), .o_busy(bz[2]), .o_fifo_level(lv[2])
    );

    int sel = 0;
    logic m_clk, m_out, m_cs, m_done, m_busy, m_rdy, m_v;
    logic [2:0] m_lvl;
    always_comb begin
        m_clk  = sc[sel];
        m_out  = so[sel];
        m_cs   = cs[sel];
        m_done = dn[sel];
        m_busy = bz[sel];
        m_lvl  = lv[sel];
        m_rdy  = sel == 0 ? b0.in_ready : sel == 1 ? b1.in_ready : b2.in_ready;
        m_v    = sel == 0 ? b0.in_valid : sel == 1 ? b1.in_valid : b2.in_valid;
    end

    int n_asrt = 0, n_fail = 0;
    logic p_clk = 1'b0, p_cs = 1'b1, p_out = 1'b0;
    int cyc = 0, last_rise = 0, lo_cnt = 0, hi_cnt = 0, starts = 0, acc = 0;
    int done_cnt = 0, max_lvl = 0, since = -1, busy_lat = -1;
    int bad_out = 0, bad_idle = 0, bad_rdy = 0, bad_lvl = 0, bad_busy = 0, bad_per = 0;
    bit saw_full = 1'b0;
    bit bits[$];
    logic [31:0] cap_q[$], exp_q[$];
    int len_q[$], rise_q[$], gap_q[$];

    always @(posedge clk or negedge rst_n)
        if (!rst_n) acc = 0;
        else if (m_v && m_rdy) acc++;

    // Decode the serial stream of the selected DUT into frames and watch timing rules.
    always @(negedge clk) begin
        logic [31:0] w;
        cyc++;
        if (!rst_n) starts = 0;
        if (p_cs && !m_cs) begin
            gap_q.push_back(hi_cnt);
            hi_cnt = 0;
            starts++;
        end
        if (!p_cs && m_cs) begin
            w = '0;
            foreach (bits[i])
                if (bits[i]) w |= (sel != 1) ? (32'd1 << (bits.size() - 1 - i)) : (32'd1 << i);
            cap_q.push_back(w);
            len_q.push_back(lo_cnt);
            rise_q.push_back(bits.size());
            bits.delete();
            lo_cnt = 0;
        end
        if (m_cs) hi_cnt++;
        else begin
            lo_cnt++;
            if (!p_clk && m_clk) begin
                if (bits.size() > 0 && cyc - last_rise != 2 * ((sel == 2) ? 3 : 1)) bad_per++;
                last_rise = cyc;
                bits.push_back(m_out);
            end
        end
        if (m_out != p_out && !(p_clk && !m_clk) && p_cs == m_cs) bad_out++;
        if (m_cs && (m_clk || m_out)) bad_idle++;
        if (m_rdy != (m_lvl < 3'd4)) bad_rdy++;
        if (int'(m_lvl) != acc - starts) bad_lvl++;
        if ((!m_cs || m_lvl != 3'd0) && !m_busy) bad_busy++;
        if (int'(m_lvl) > max_lvl) max_lvl = int'(m_lvl);
        if (!m_rdy) saw_full = 1'b1;
        done_cnt += int'(m_done);
        if (m_done) since = 0;
        else if (since >= 0) since++;
        if (since >= 0 && !m_busy && busy_lat < 0) busy_lat = since;
        p_clk = m_clk;
        p_cs  = m_cs;
        p_out = m_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input int s, input logic v, input logic [31:0] d);
        if (s == 0) begin b0.in_valid = v; b0.in_data = d; end
        else if (s == 1) begin b1.in_valid = v; b1.in_data = d; end
        else begin b2.in_valid = v; b2.in_data = d[15:0]; end
    endtask

    function automatic logic rdy(input int s);
        return s == 0 ? b0.in_ready : s == 1 ? b1.in_ready : b2.in_ready;
    endfunction

    task automatic push(input int s, input logic [31:0] d);
        int n = 0;
        drv(s, 1'b1, d);
        while (!rdy(s) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("push_wait", n < 1000, 1);
        @(posedge clk);
        #1 drv(s, 1'b0, $urandom);
        exp_q.push_back(s == 2 ? {16'd0, d[15:0]} : d);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        @(negedge clk);
        while ((m_busy || !m_cs) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_drain"}, n < 5000, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic clr_mon();
        cap_q.delete(); len_q.delete(); rise_q.delete(); gap_q.delete(); exp_q.delete();
        done_cnt = 0;
    endtask

    task automatic check_inv(input string tag);
        chk({tag, "_out_timing"}, bad_out, 0);
        chk({tag, "_idle_lines"}, bad_idle, 0);
        chk({tag, "_ready"}, bad_rdy, 0);
        chk({tag, "_level"}, bad_lvl, 0);
        chk({tag, "_busy"}, bad_busy, 0);
        chk({tag, "_period"}, bad_per, 0);
        bad_out = 0; bad_idle = 0; bad_rdy = 0; bad_lvl = 0; bad_busy = 0; bad_per = 0;
    endtask

    task automatic check_frames(input string tag, input int len, input int gap, input int nb);
        int n = exp_q.size();
        int g;
        chk({tag, "_nframes"}, cap_q.size(), n);
        chk({tag, "_ndone"}, done_cnt, n);
        for (int i = 0; i < n && cap_q.size() > 0; i++) begin
            chk($sformatf("%s_data%0d", tag, i), cap_q.pop_front(), exp_q.pop_front());
            chk($sformatf("%s_cslow%0d", tag, i), len_q.pop_front(), len);
            chk($sformatf("%s_rises%0d", tag, i), rise_q.pop_front(), nb);
            g = gap_q.pop_front();
            if (i > 0) chk($sformatf("%s_gap%0d", tag, i), g, gap);
        end
        check_inv(tag);
        clr_mon();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drv(0, 1'b0, 0); drv(1, 1'b0, 0); drv(2, 1'b0, 0);
        #12;
        chk("rst_cs_n", m_cs, 1);
        chk("rst_ser_clk", m_clk, 0);
        chk("rst_ser_out", m_out, 0);
        chk("rst_done", m_done, 0);
        chk("rst_busy", m_busy, 0);
        chk("rst_level", m_lvl, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", m_rdy, 1);

        since = -1; busy_lat = -1;
        push(0, 32'hA5C30F81);
        drain("t1");
        chk("t1_busy_low", busy_lat > 0 && busy_lat <= 3, 1);
        check_frames("t1", 64, 2, 32);

        sel = 1;
        push(1, 32'h00000001);
        drain("t2");
        chk("t2_out_after", m_out, 0);
        check_frames("t2", 64, 1, 32);

        sel = 0;
        max_lvl = 0; saw_full = 1'b0;
        for (int i = 0; i < 6; i++) push(0, $urandom);
        drain("t3");
        chk("t3_peak_level", max_lvl, 4);
        chk("t3_ready_low", saw_full, 1);
        check_frames("t3", 64, 2, 32);

        sel = 2;
        push(2, 32'h0000BEEF);
        push(2, $urandom);
        push(2, $urandom);
        drain("t4");
        check_frames("t4", 96, 2, 16);

        sel = 0;
        push(0, $urandom);
        push(0, $urandom);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cs_n", m_cs, 1);
        chk("t5_ser_clk", m_clk, 0);
        chk("t5_level", m_lvl, 0);
        chk("t5_busy", m_busy, 0);
        repeat (3) @(negedge clk);
        chk("t5_no_done", done_cnt, 0);
        rst_n = 1'b1;
        check_inv("t5_abort");
        clr_mon();
        push(0, 32'h12345678);
        drain("t5");
        check_frames("t5", 64, 2, 32);

        sel = 1;
        push(1, 32'hFFFFFFFF);
        push(1, 32'h00000000);
        push(1, $urandom);
        push(1, $urandom);
        drain("t6");
        check_frames("t6", 64, 1, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
